coreahblite_slavearb: RTL and testbench

Per-slave-slot arbiter that shares one AHB-Lite slave slot between master 0 and master 1 in the CoreAHBLite matrix. It sits between the two master-side address decoders (one decoded slot-hit per master) and the slave-side address/data multiplexers. It owns a registered address-phase select and a registered data-phase select, and provides:

- round-robin or fixed-priority arbitration;
- burst continuity with a fairness cap;
- HMASTLOCK honouring;
- per-master wait generation.

---
 rtl/coreahblite_slavearb.sv | 151 +++++++++++++++
 tb/tb_coreahblite_slavearb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coreahblite_slavearb.sv
// Per-slave-slot arbiter sharing one AHB-Lite slave between master 0 and master 1.
// Latency: grant registered one decision edge after a request; DATASEL lags ADDRSEL by one decision edge.
// Backpressure: HREADY_S=0 freezes all state; a losing master is stalled through Mx_WAIT.
//
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   Mx_REQ/Mx_SEQ/Mx_LOCK per-master slot hit, HTRANS==SEQ, HMASTLOCK (x = 0, 1)
//   HREADY_S              slave HREADYOUT; a high level at a rising edge marks a decision point
//   ADDRSEL[1:0]          one-hot address-phase owner (bit0 = M0, bit1 = M1), 00 = no owner
//   DATASEL[1:0]          one-hot data-phase owner, routes HRDATA/HRESP/HREADY back
//   FORCE_NONSEQ          present the current slave-side address phase as NONSEQ
//   M0_WAIT, M1_WAIT      stall the requesting master while it does not own the slot
module coreahblite_slavearb #(
   parameter int PRIORITY_M0 = 0,
   parameter int MAX_HOLD    = 16
) (
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       M0_REQ,
   input  logic       M0_SEQ,
   input  logic       M0_LOCK,
   input  logic       M1_REQ,
   input  logic       M1_SEQ,
   input  logic       M1_LOCK,
   input  logic       HREADY_S,
   output logic [1:0] ADDRSEL,
   output logic [1:0] DATASEL,
   output logic       FORCE_NONSEQ,
   output logic       M0_WAIT,
   output logic       M1_WAIT
);

   // The state encoding is the one-hot ADDRSEL value itself, so the owner
   // select comes straight off the state flops with no decode.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_OWN0 = 2'b01,
      ST_OWN1 = 2'b10
   } state_t;

   localparam bit       FIXED_PRI = (PRIORITY_M0 != 0);
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic [1:0] datasel_q, datasel_d;
   logic       force_nonseq_q, force_nonseq_d;
   logic [7:0] hold_q, hold_d;
   logic       last_q, last_d;          // 0 = M0 granted last, 1 = M1

   // Current owner (x) and the other master (y), viewed from the owner.
   logic x_is_m1;
   logic x_req, x_seq, x_lock;
   logic y_req, y_seq;
   logic keep_x;
   logic y_may_win;

   always_comb begin
      x_is_m1 = (state_q == ST_OWN1);
      x_req   = x_is_m1 ? M1_REQ  : M0_REQ;
      x_seq   = x_is_m1 ? M1_SEQ  : M0_SEQ;
      x_lock  = x_is_m1 ? M1_LOCK : M0_LOCK;
      y_req   = x_is_m1 ? M0_REQ  : M1_REQ;
      y_seq   = x_is_m1 ? M0_SEQ  : M1_SEQ;

      // Lock holds the slot even across IDLE beats (x_req low); an
      // uncontested owner keeps it; a SEQ burst keeps it until the cap.
      keep_x = x_lock
             | (x_req & ~y_req)
             | (x_req & x_seq & (hold_q < HOLD_LIM));

      // Under fixed priority only M0 may take the slot from a busy owner,
      // which is the case exactly when the owner is M1.
      y_may_win = ~FIXED_PRI | x_is_m1;
   end

   always_comb begin
      state_d        = state_q;
      datasel_d      = datasel_q;
      force_nonseq_d = force_nonseq_q;
      hold_d         = hold_q;
      last_d         = last_q;

      if (HREADY_S) begin
         // The address phase accepted at this edge becomes the data phase.
         datasel_d      = state_q & {M1_REQ, M0_REQ};
         force_nonseq_d = 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (M0_REQ && M1_REQ) begin
                  state_d = (FIXED_PRI || last_q) ? ST_OWN0 : ST_OWN1;
               end else if (M0_REQ) begin
                  state_d = ST_OWN0;
               end else if (M1_REQ) begin
                  state_d = ST_OWN1;
               end
            end
            ST_OWN0, ST_OWN1: begin
               if (keep_x) begin
                  state_d = state_q;
               end else if (y_req && y_may_win) begin
                  state_d = x_is_m1 ? ST_OWN0 : ST_OWN1;
                  // The incoming master may be resuming a burst that was cut
                  // off; its first beat on this slave must look like a start.
                  force_nonseq_d = y_seq;
               end else if (x_req) begin
                  state_d = state_q;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase

         if (state_d != state_q) begin
            hold_d = 8'd0;
            if (state_d != ST_IDLE) begin
               last_d = (state_d == ST_OWN1);
            end
         end else if ((state_q != ST_IDLE) && x_req && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 8'd1;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q        <= ST_IDLE;
         datasel_q      <= 2'b00;
         force_nonseq_q <= 1'b0;
         hold_q         <= 8'd0;
         last_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         datasel_q      <= datasel_d;
         force_nonseq_q <= force_nonseq_d;
         hold_q         <= hold_d;
         last_q         <= last_d;
      end
   end

   assign ADDRSEL      = state_q;
   assign DATASEL      = datasel_q;
   assign FORCE_NONSEQ = force_nonseq_q;
   assign M0_WAIT      = M0_REQ & ~state_q[0];
   assign M1_WAIT      = M1_REQ & ~state_q[1];

endmodule

// File: tb/tb_coreahblite_slavearb.sv
// Testbench for coreahblite_slavearb: a round-robin and a fixed-priority instance share stimulus.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: HREADY_S stalls are driven directly and checked through frozen outputs.
module tb_coreahblite_slavearb;

   localparam int MAXH = 4;

   logic       clk;
   logic       rst;
   logic       hr;
   logic [1:0] req, seq, lock;

   logic [1:0] addr_a, dsel_a, wait_a;
   logic       fns_a;
   logic [1:0] addr_b, dsel_b, wait_b;
   logic       fns_b;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   coreahblite_slavearb #(.PRIORITY_M0(0), .MAX_HOLD(MAXH)) dut_rr (
      .HCLK(clk), .HRESET(rst),
      .M0_REQ(req[0]), .M0_SEQ(seq[0]), .M0_LOCK(lock[0]),
      .M1_REQ(req[1]), .M1_SEQ(seq[1]), .M1_LOCK(lock[1]),
      .HREADY_S(hr),
      .ADDRSEL(addr_a), .DATASEL(dsel_a), .FORCE_NONSEQ(fns_a),
      .M0_WAIT(wait_a[0]), .M1_WAIT(wait_a[1])
   );

   coreahblite_slavearb #(.PRIORITY_M0(1), .MAX_HOLD(MAXH)) dut_fp (
      .HCLK(clk), .HRESET(rst),
      .M0_REQ(req[0]), .M0_SEQ(seq[0]), .M0_LOCK(lock[0]),
      .M1_REQ(req[1]), .M1_SEQ(seq[1]), .M1_LOCK(lock[1]),
      .HREADY_S(hr),
      .ADDRSEL(addr_b), .DATASEL(dsel_b), .FORCE_NONSEQ(fns_b),
      .M0_WAIT(wait_b[0]), .M1_WAIT(wait_b[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: owner as an index (-1 = nobody), per configuration.
   int         m_own  [2];
   int         m_last [2];
   int         m_hold [2];
   logic [1:0] m_dsel [2];
   logic       m_fns  [2];

   function automatic logic [1:0] onehot(input int who);
      logic [1:0] r;
      r = 2'b00;
      if (who >= 0) r[who] = 1'b1;
      return r;
   endfunction

   task automatic model_reset(input int c);
      m_own[c]  = -1;
      m_last[c] = 0;
      m_hold[c] = 0;
      m_dsel[c] = 2'b00;
      m_fns[c]  = 1'b0;
   endtask

   task automatic model_step(input int c, input int pri);
      int  nxt;
      int  x;
      int  y;
      bit  stay;
      if (rst) begin
         model_reset(c);
      end else if (hr) begin
         m_dsel[c] = (m_own[c] >= 0 && req[m_own[c]]) ? onehot(m_own[c]) : 2'b00;
         if (m_own[c] < 0) begin
            if (req[0] && req[1]) nxt = (pri != 0) ? 0 : 1 - m_last[c];
            else if (req[0])      nxt = 0;
            else if (req[1])      nxt = 1;
            else                  nxt = -1;
         end else begin
            x    = m_own[c];
            y    = 1 - x;
            stay = lock[x] || (req[x] && !req[y]) || (req[x] && seq[x] && m_hold[c] < MAXH - 1);
            if (stay)                             nxt = x;
            else if (req[y] && (pri == 0 || y == 0)) nxt = y;
            else if (req[x])                      nxt = x;
            else                                  nxt = -1;
         end
         m_fns[c] = (m_own[c] >= 0 && nxt >= 0 && nxt != m_own[c] && seq[nxt]);
         if (nxt != m_own[c]) begin
            m_hold[c] = 0;
            if (nxt >= 0) m_last[c] = nxt;
         end else if (nxt >= 0 && req[nxt]) begin
            m_hold[c] = (m_hold[c] + 1 > MAXH) ? MAXH : m_hold[c] + 1;
         end
         m_own[c] = nxt;
      end
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // One clock: step the model on the edge, then compare both instances.
   task automatic tick();
      @(posedge clk);
      model_step(0, 0);
      model_step(1, 1);
      #1;
      cyc++;
      chk("rr_addrsel", {6'd0, addr_a}, {6'd0, onehot(m_own[0])});
      chk("rr_datasel", {6'd0, dsel_a}, {6'd0, m_dsel[0]});
      chk("rr_fnseq",   {7'd0, fns_a},  {7'd0, m_fns[0]});
      chk("rr_wait",    {6'd0, wait_a}, {6'd0, req & ~onehot(m_own[0])});
      chk("fp_addrsel", {6'd0, addr_b}, {6'd0, onehot(m_own[1])});
      chk("fp_datasel", {6'd0, dsel_b}, {6'd0, m_dsel[1]});
      chk("fp_fnseq",   {7'd0, fns_b},  {7'd0, m_fns[1]});
      chk("fp_wait",    {6'd0, wait_b}, {6'd0, req & ~onehot(m_own[1])});
   endtask

   task automatic drive(input logic r, input logic h, input logic [1:0] q,
                        input logic [1:0] s, input logic [1:0] l);
      rst  = r;
      hr   = h;
      req  = q;
      seq  = s;
      lock = l;
   endtask

   typedef struct {
      logic       rst;
      logic       hr;
      logic [1:0] req;
      logic [1:0] seq;
      logic [1:0] lock;
      logic [1:0] e_addr;
      logic [1:0] e_dsel;
      logic       e_fns;
      logic [1:0] e_wait;
   } vec_t;

   vec_t tbl[14];

   initial begin
      // Round-robin instance, hand-derived: reset, single master, alternation,
      // stall freeze, reset during a stall.
      tbl[0]  = '{1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00};
      tbl[1]  = '{1, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b11};
      tbl[2]  = '{0, 1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 0, 2'b00};
      tbl[3]  = '{0, 1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 0, 2'b00};
      tbl[4]  = '{0, 1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 0, 2'b00};
      tbl[5]  = '{0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00};
      tbl[6]  = '{0, 1, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 0, 2'b01};
      tbl[7]  = '{0, 1, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 0, 2'b10};
      tbl[8]  = '{0, 1, 2'b11, 2'b00, 2'b00, 2'b10, 2'b01, 0, 2'b01};
      tbl[9]  = '{0, 0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b01, 0, 2'b01};
      tbl[10] = '{0, 0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b01, 0, 2'b01};
      tbl[11] = '{0, 1, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 0, 2'b10};
      tbl[12] = '{1, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b11};
      tbl[13] = '{0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00};

      model_reset(0);
      model_reset(1);
      drive(1, 1, 2'b00, 2'b00, 2'b00);

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].rst, tbl[i].hr, tbl[i].req, tbl[i].seq, tbl[i].lock);
         tick();
         chk($sformatf("tbl%0d_addrsel", i), {6'd0, addr_a}, {6'd0, tbl[i].e_addr});
         chk($sformatf("tbl%0d_datasel", i), {6'd0, dsel_a}, {6'd0, tbl[i].e_dsel});
         chk($sformatf("tbl%0d_fnseq", i),   {7'd0, fns_a},  {7'd0, tbl[i].e_fns});
         chk($sformatf("tbl%0d_wait", i),    {6'd0, wait_a}, {6'd0, tbl[i].e_wait});
      end

      // Burst cap: M0 NONSEQ+SEQ burst, M1 (resuming SEQ) contends from beat 2,
      // with a 3-cycle stall that must not advance the hold count.
      drive(1, 1, 2'b00, 2'b00, 2'b00); tick();
      drive(0, 1, 2'b01, 2'b00, 2'b00); tick();
      chk("burst_grant", {6'd0, addr_a}, 8'h01);
      tick();
      chk("burst_beat1_dsel", {6'd0, dsel_a}, 8'h01);
      drive(0, 1, 2'b11, 2'b11, 2'b00); tick();
      chk("burst_beat2_keep", {6'd0, addr_a}, 8'h01);
      chk("burst_m1_wait", {7'd0, wait_a[1]}, 8'h01);
      hr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("burst_stall%0d_addr", i), {6'd0, addr_a}, 8'h01);
         chk($sformatf("burst_stall%0d_dsel", i), {6'd0, dsel_a}, 8'h01);
      end
      hr = 1'b1;
      tick();
      chk("burst_beat3_keep", {6'd0, addr_a}, 8'h01);
      tick();
      chk("burst_cap_switch", {6'd0, addr_a}, 8'h02);
      chk("burst_cap_fnseq", {7'd0, fns_a}, 8'h01);
      chk("burst_cap_m0_wait", {7'd0, wait_a[0]}, 8'h01);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("burst_m1_hold%0d", i), {6'd0, addr_a}, 8'h02);
         chk($sformatf("burst_m0_wait%0d", i), {7'd0, wait_a[0]}, 8'h01);
         chk($sformatf("burst_fnseq_clr%0d", i), {7'd0, fns_a}, 8'h00);
      end
      tick();
      chk("burst_regrant_m0", {6'd0, addr_a}, 8'h01);
      chk("burst_regrant_fnseq", {7'd0, fns_a}, 8'h01);
      chk("burst_regrant_wait", {7'd0, wait_a[0]}, 8'h00);

      // Lock: M0 holds through IDLE gaps while M1 requests throughout.
      drive(1, 1, 2'b00, 2'b00, 2'b00); tick();
      drive(0, 1, 2'b01, 2'b00, 2'b01); tick();
      chk("lock_grant", {6'd0, addr_a}, 8'h01);
      for (int i = 0; i < 10; i++) begin
         req = {1'b1, (i % 2 == 1)};
         tick();
         chk($sformatf("lock_hold%0d", i), {6'd0, addr_a}, 8'h01);
         chk($sformatf("lock_m1_wait%0d", i), {7'd0, wait_a[1]}, 8'h01);
      end
      drive(0, 0, 2'b10, 2'b00, 2'b00); tick();
      chk("lock_drop_stalled", {6'd0, addr_a}, 8'h01);
      hr = 1'b1;
      tick();
      chk("lock_drop_switch", {6'd0, addr_a}, 8'h02);

      // Fixed priority: M0 keeps the slot against continuous M1 NONSEQ.
      drive(1, 1, 2'b00, 2'b00, 2'b00); tick();
      drive(0, 1, 2'b11, 2'b00, 2'b00);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("fixpri_addr%0d", i), {6'd0, addr_b}, 8'h01);
         chk($sformatf("fixpri_m1_wait%0d", i), {7'd0, wait_b[1]}, 8'h01);
      end

      // Random traffic against the model for both instances.
      for (int i = 0; i < 3000; i++) begin
         logic [1:0] r;
         rst  = ($urandom_range(0, 99) == 0);
         hr   = ($urandom_range(0, 99) < 75);
         r[0] = ($urandom_range(0, 99) < 60);
         r[1] = ($urandom_range(0, 99) < 60);
         req  = r;
         seq  = r & 2'($urandom_range(0, 3));
         lock[0] = ($urandom_range(0, 99) < 20);
         lock[1] = ($urandom_range(0, 99) < 20);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
